fifo_sync: RTL and testbench

FIFO_SYNC -- requirements
Module: fifo_sync

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_mem.sv | 27 ++
 rtl/fifo_sync.sv | 151 +++++++++++++++
 tb/tb_fifo_sync.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and elaboration helpers for the synchronous FIFO.
// Mode selects how the read side presents data: registered pop or first-word-fall-through.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic bit is_pow2(input int unsigned n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array, one synchronous write port
// and one asynchronous read port. Contents are never reset or cleared.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0]    rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync.sv
// Single-clock FIFO: pointers, occupancy count, status/sticky-error flags and
// the read-side output stage (registered pop or first-word-fall-through).
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int         DEPTH      = 16,
  parameter int         DATA_WIDTH = 8,
  parameter int         AF_THRESH  = DEPTH - 2,
  parameter int         AE_THRESH  = 2,
  parameter fifo_mode_e MODE       = FIFO_STD
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [DATA_WIDTH-1:0]    data_i,
  input  logic                     rd_en_i,
  input  logic                     flush_i,
  input  logic                     clr_err_i,
  output logic [DATA_WIDTH-1:0]    data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  generate
    if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("fifo_sync: DEPTH must be a power of two and >= 2");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
      $error("fifo_sync: DATA_WIDTH must be >= 1");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
      $error("fifo_sync: AF_THRESH must be in 1..DEPTH");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
      $error("fifo_sync: AE_THRESH must be in 0..DEPTH-1");
    end
  endgenerate

  logic [CW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  is_empty, is_full;
  logic                  rd_accept, wr_accept;
  logic [DATA_WIDTH-1:0] head_data;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));

  // A read frees a slot in the same cycle, so a full FIFO still takes a
  // write alongside a read. Flush suppresses both requests.
  assign rd_accept = rd_en_i && !is_empty && !flush_i;
  assign wr_accept = wr_en_i && !flush_i && (!is_full || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + CW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + CW'(1);
      case ({wr_accept, rd_accept})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Sticky errors: a new event in the same cycle as clr_err_i keeps the flag set.
  always_comb begin
    overflow_d  = (wr_en_i && !wr_accept && !flush_i) || (overflow_q && !clr_err_i);
    underflow_d = (rd_en_i && is_empty && !flush_i) || (underflow_q && !clr_err_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (wr_accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (data_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (head_data)
  );

  generate
    if (MODE == FIFO_STD) begin : g_std
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      // Popped word is captured on the accepting edge and held afterwards;
      // valid is a one-cycle pulse per accepted read.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_accept;
          if (rd_accept) data_q <= head_data;
        end
      end

      assign data_o  = data_q;
      assign valid_o = valid_q;
    end else begin : g_fwft
      assign data_o  = head_data;
      assign valid_o = !is_empty;
    end
  endgenerate

  assign count_o        = count_q;
  assign empty_o        = is_empty;
  assign full_o         = is_full;
  assign almost_full_o  = (count_q >= CW'(AF_THRESH));
  assign almost_empty_o = (count_q <= CW'(AE_THRESH));
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_fifo_sync.sv
// Directed bench for fifo_sync (DEPTH=8, DATA_WIDTH=4): a registered-read instance
// checked through a scoreboard monitor, plus a small first-word-fall-through instance.
module tb_fifo_sync;
  import fifo_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, rd = 1'b0, fl = 1'b0, clr = 1'b0;
  logic [3:0] din = '0;
  logic [3:0] s_data, s_count;
  logic       s_valid, s_full, s_empty, s_af, s_ae, s_ovf, s_udf;

  logic       f_wr = 1'b0, f_rd = 1'b0, f_fl = 1'b0, f_clr = 1'b0;
  logic [3:0] f_din = '0;
  logic [3:0] f_data, f_count;
  logic       f_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_udf;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] mdl[$];    // expected FIFO contents
  logic [3:0] exp_q[$];  // expected read-out words, in order

  always #5 clk = ~clk;

  fifo_sync #(.DEPTH(8), .DATA_WIDTH(4), .AF_THRESH(6), .AE_THRESH(2), .MODE(FIFO_STD)) u_std (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr), .data_i(din), .rd_en_i(rd),
    .flush_i(fl), .clr_err_i(clr), .data_o(s_data), .valid_o(s_valid),
    .full_o(s_full), .empty_o(s_empty), .almost_full_o(s_af), .almost_empty_o(s_ae),
    .count_o(s_count), .overflow_o(s_ovf), .underflow_o(s_udf)
  );

  fifo_sync #(.DEPTH(8), .DATA_WIDTH(4), .AF_THRESH(6), .AE_THRESH(2), .MODE(FIFO_FWFT)) u_fwft (
    .clk_i(clk), .rst_i(rst), .wr_en_i(f_wr), .data_i(f_din), .rd_en_i(f_rd),
    .flush_i(f_fl), .clr_err_i(f_clr), .data_o(f_data), .valid_o(f_valid),
    .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_af), .almost_empty_o(f_ae),
    .count_o(f_count), .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // One cycle of stimulus; the scoreboard learns of every read that should be accepted.
  task automatic op(input bit w, input logic [3:0] d, input bit r, input bit f = 1'b0,
                    input bit c = 1'b0);
    bit rd_acc, wr_acc;
    wr = w; din = d; rd = r; fl = f; clr = c;
    rd_acc = r && !f && (mdl.size() > 0);
    wr_acc = w && !f && ((mdl.size() < 8) || rd_acc);
    if (f) mdl.delete();
    if (rd_acc) exp_q.push_back(mdl.pop_front());
    if (wr_acc) mdl.push_back(d);
    @(posedge clk); #1;
    wr = 1'b0; rd = 1'b0; fl = 1'b0; clr = 1'b0;
  endtask

  // Monitor: every valid_o pulse must match the next expected word.
  always @(negedge clk) begin
    logic [3:0] e;
    if (!rst && s_valid) begin
      if (exp_q.size() == 0) begin
        chk("std_spurious_valid", int'(s_valid), 0);
      end else begin
        e = exp_q.pop_front();
        $display("read: data_o=%h expected=%h", s_data, e);
        chk("std_rdata", int'(s_data), int'(e));
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_count", s_count, 0);
    chk("rst_empty", s_empty, 1);
    chk("rst_full", s_full, 0);
    chk("rst_af", s_af, 0);
    chk("rst_ae", s_ae, 1);
    chk("rst_ovf", s_ovf, 0);
    chk("rst_udf", s_udf, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_data", s_data, 0);

    // Fill 1..8, then one write too many.
    for (int i = 1; i <= 8; i++) begin
      op(1'b1, 4'(i), 1'b0);
      chk("fill_count", s_count, i);
      chk("fill_full", s_full, (i == 8) ? 1 : 0);
      chk("fill_af", s_af, (i >= 6) ? 1 : 0);
      chk("fill_ae", s_ae, (i <= 2) ? 1 : 0);
    end
    op(1'b1, 4'h9, 1'b0);
    chk("ovf_set", s_ovf, 1);
    chk("ovf_count", s_count, 8);
    for (int i = 0; i < 8; i++) begin
      op(1'b0, 4'h0, 1'b1);
      chk("drain_count", s_count, 7 - i);
    end
    chk("drain_empty", s_empty, 1);
    chk("ovf_sticky", s_ovf, 1);
    op(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", s_ovf, 0);

    // Simultaneous read+write while full.
    for (int i = 1; i <= 8; i++) op(1'b1, 4'(i), 1'b0);
    op(1'b1, 4'hA, 1'b1);
    chk("fullrw_count", s_count, 8);
    chk("fullrw_ovf", s_ovf, 0);
    chk("fullrw_full", s_full, 1);
    for (int i = 0; i < 8; i++) op(1'b0, 4'h0, 1'b1);
    chk("fullrw_empty", s_empty, 1);

    // Simultaneous read+write while empty: read rejected, write taken.
    op(1'b1, 4'h5, 1'b1);
    chk("emptyrw_udf", s_udf, 1);
    chk("emptyrw_count", s_count, 1);
    chk("emptyrw_valid", s_valid, 0);
    op(1'b0, 4'h0, 1'b1);
    chk("emptyrw_count2", s_count, 0);

    // Pointer wrap at a steady occupancy of 3.
    op(1'b1, 4'hC, 1'b0);
    op(1'b1, 4'hD, 1'b0);
    op(1'b1, 4'hE, 1'b0);
    for (int i = 0; i < 20; i++) begin
      op(1'b1, 4'(i), 1'b1);
      chk("wrap_count", s_count, 3);
    end
    for (int i = 0; i < 3; i++) op(1'b0, 4'h0, 1'b1);
    chk("wrap_empty", s_empty, 1);

    // Flush with a concurrent write, then error clearing.
    for (int i = 0; i < 5; i++) op(1'b1, 4'(i + 3), 1'b0);
    chk("pre_flush_count", s_count, 5);
    op(1'b1, 4'h7, 1'b0, 1'b1);
    chk("flush_count", s_count, 0);
    chk("flush_empty", s_empty, 1);
    chk("flush_valid", s_valid, 0);
    chk("flush_udf_kept", s_udf, 1);
    chk("flush_ovf_kept", s_ovf, 0);
    op(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_udf", s_udf, 0);
    op(1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("set_wins_udf", s_udf, 1);
    op(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("clr_udf2", s_udf, 0);

    // Reset mid-transfer discards everything.
    op(1'b1, 4'h1, 1'b0);
    op(1'b1, 4'h2, 1'b0);
    rst = 1'b1;
    mdl.delete();
    @(posedge clk); #1 rst = 1'b0;
    chk("midrst_count", s_count, 0);
    chk("midrst_empty", s_empty, 1);
    chk("midrst_valid", s_valid, 0);
    op(1'b0, 4'h0, 1'b1);
    chk("midrst_udf", s_udf, 1);

    repeat (3) @(posedge clk);
    #1 chk("sb_drained", exp_q.size(), 0);

    // First-word-fall-through instance.
    chk("fwft_rst_valid", f_valid, 0);
    f_wr = 1'b1; f_din = 4'h3;
    @(posedge clk); #1 f_wr = 1'b0;
    chk("fwft_valid", f_valid, 1);
    chk("fwft_data", f_data, 3);
    chk("fwft_count", f_count, 1);
    f_rd = 1'b1;
    @(posedge clk); #1 f_rd = 1'b0;
    chk("fwft_valid_after_rd", f_valid, 0);
    chk("fwft_empty", f_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
